// File: rtl/pio_in_capture_if.sv
// pio_in_capture_if
//   Avalon-MM slave bus bundle for the input-capture PIO.
//   address    : word address of the 4-word register window
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
//   irq        : level interrupt, active high
interface pio_in_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_in_capture.sv
// pio_in_capture
//   Parametrised input port: synchronizer, optional per-bit debounce,
//   per-bit edge capture (write-1-to-clear) and a maskable level irq.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-high
//   in_port : asynchronous external inputs
//   bus     : Avalon-MM slave (address, chipselect, write_n, writedata,
//             readdata, irq)
//   Register window: 0 data (RO), 1 irq mask (RW), 2 reserved,
//   3 edgecapture (W1C).
module pio_in_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  pio_in_capture_if.slave  bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        stable_d = sync_in;
      end
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0]            sync_prev_q;
      logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

      // Counter restarts on agreement with the stable bit or on any
      // sync_in change; a run that reaches the terminal count is accepted.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
          if ((sync_in[i] == stable_q[i]) || (sync_in[i] != sync_prev_q[i])) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_TC) begin
            stable_d[i] = sync_in[i];
            cnt_d[i]    = '0;
          end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_prev_q <= '0;
          cnt_q       <= '0;
        end else begin
          sync_prev_q <= sync_in;
          cnt_q       <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = stable_q & ~prev_q;
      1:       edge_det = ~stable_q & prev_q;
      default: edge_det = stable_q ^ prev_q;
    endcase
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  always_comb begin
    prev_d = stable_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr_en && (bus.address == 2'd1)) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && (bus.address == 2'd3)) w1c    = bus.writedata[WIDTH-1:0];
    // A newly detected edge overrides a clear of the same bit.
    edgecap_d = (edgecap_q & ~w1c) | edge_det;
  end

  // Read mux samples pre-write register contents.
  always_comb begin
    case (bus.address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      stable_q   <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      stable_q   <= stable_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_pio_in_capture.sv
module tb_pio_in_capture;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [7:0]  in_port;
  logic        cs, wn;
  logic [1:0]  addr;
  logic [31:0] wdata;

  pio_in_capture_if bus0 ();
  pio_in_capture_if bus1 ();
  pio_in_capture_if bus2 ();

  assign bus0.address = addr;  assign bus0.chipselect = cs;
  assign bus0.write_n = wn;    assign bus0.writedata  = wdata;
  assign bus1.address = addr;  assign bus1.chipselect = cs;
  assign bus1.write_n = wn;    assign bus1.writedata  = wdata;
  assign bus2.address = addr;  assign bus2.chipselect = cs;
  assign bus2.write_n = wn;    assign bus2.writedata  = wdata;

  pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0))
    dut0 (.clk(clk), .reset(reset), .in_port(in_port), .bus(bus0));
  pio_in_capture #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2))
    dut1 (.clk(clk), .reset(reset), .in_port(in_port), .bus(bus1));
  pio_in_capture #(.WIDTH(8), .SYNC_STAGES(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1))
    dut2 (.clk(clk), .reset(reset), .in_port(in_port), .bus(bus2));

  int syn_n [3] = '{2, 3, 4};
  int dbc   [3] = '{0, 4, 1};
  int ety   [3] = '{0, 2, 1};

  // Reference model state, one set per DUT configuration.
  logic [7:0] m_pipe   [3][4];
  logic [7:0] m_sprev  [3];
  logic [7:0] m_stable [3];
  logic [7:0] m_prev   [3];
  logic [7:0] m_mask   [3];
  logic [7:0] m_ec     [3];
  int         m_run    [3][8];

  exp_t exp_q [3][$];

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  logic [7:0] cur_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a bit is accepted once sync_in has held a value
  // differing from the stable bit for DEBOUNCE_CYCLES+1 consecutive samples.
  task automatic model_step(input int d, input logic r, input logic [7:0] inp,
                            input logic c, input logic w, input logic [1:0] a,
                            input logic [31:0] wd);
    exp_t e;
    logic [7:0] s, ns, edges, clr;
    logic wr;
    if (r) begin
      for (int k = 0; k < 4; k++) m_pipe[d][k] = '0;
      for (int b = 0; b < 8; b++) m_run[d][b] = 1;
      m_sprev[d] = '0; m_stable[d] = '0; m_prev[d] = '0;
      m_mask[d] = '0;  m_ec[d] = '0;
      e.rd = '0; e.irq = 1'b0;
    end else begin
      s  = m_pipe[d][syn_n[d]-1];
      ns = s;
      if (dbc[d] != 0) begin
        ns = m_stable[d];
        for (int b = 0; b < 8; b++) begin
          if (s[b] != m_sprev[d][b]) m_run[d][b] = 1;
          else if (m_run[d][b] < 1000000) m_run[d][b] = m_run[d][b] + 1;
          if (m_run[d][b] == dbc[d] + 1 && s[b] != m_stable[d][b]) ns[b] = s[b];
        end
      end
      case (ety[d])
        0:       edges = m_stable[d] & ~m_prev[d];
        1:       edges = ~m_stable[d] & m_prev[d];
        default: edges = m_stable[d] ^ m_prev[d];
      endcase
      case (a)
        2'd0:    e.rd = {24'h0, m_stable[d]};
        2'd1:    e.rd = {24'h0, m_mask[d]};
        2'd3:    e.rd = {24'h0, m_ec[d]};
        default: e.rd = 32'h0;
      endcase
      wr  = c && !w;
      clr = (wr && a == 2'd3) ? wd[7:0] : 8'h00;
      if (wr && a == 2'd1) m_mask[d] = wd[7:0];
      m_ec[d]     = (m_ec[d] & ~clr) | edges;
      m_prev[d]   = m_stable[d];
      m_stable[d] = ns;
      m_sprev[d]  = s;
      for (int k = 3; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
      m_pipe[d][0] = inp;
      e.irq = |(m_ec[d] & m_mask[d]);
    end
    exp_q[d].push_back(e);
  endtask

  task automatic step(input logic r, input logic [7:0] inp, input logic c,
                      input logic w, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = r; in_port = inp; cs = c; wn = w; addr = a; wdata = wd;
    for (int d = 0; d < 3; d++) model_step(d, r, inp, c, w, a, wd);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    repeat (n) step(1'b0, cur_in, 1'b1, 1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, cur_in, 1'b1, 1'b0, a, d);
  endtask

  function automatic logic [32:0] act_of(input int d);
    case (d)
      0:       return {bus0.readdata, bus0.irq};
      1:       return {bus1.readdata, bus1.irq};
      default: return {bus2.readdata, bus2.irq};
    endcase
  endfunction

  // Monitor: compares every cycle the DUT presents a registered response.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      for (int d = 0; d < 3; d++) begin
        if (exp_q[d].size() > 0) begin
          exp_t e;
          logic [32:0] act;
          e   = exp_q[d].pop_front();
          act = act_of(d);
          checks++;
          if (act[32:1] !== e.rd) begin
            errors++;
            $display("FAIL readdata dut%0d cycle %0d: got %h expected %h", d, cycle, act[32:1], e.rd);
          end
          checks++;
          if (act[0] !== e.irq) begin
            errors++;
            $display("FAIL irq dut%0d cycle %0d: got %b expected %b", d, cycle, act[0], e.irq);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_port = 8'h00; cs = 1'b0; wn = 1'b1; addr = 2'd0; wdata = 32'h0;

    // Reset with inputs held, then watch data fill through the pipeline.
    cur_in = 8'hA5;
    repeat (3) step(1'b1, cur_in, 1'b1, 1'b1, 2'd0, 32'h0);
    idle(10, 2'd0);

    // Mask bit0, clear, toggle bit0 low then high, then W1C it.
    wr(2'd1, 32'h1);
    wr(2'd3, 32'hFFFF_FFFF);
    cur_in = 8'hA4; idle(12, 2'd3);
    wr(2'd3, 32'hFFFF_FFFF);
    cur_in = 8'hA5; idle(12, 2'd3);
    wr(2'd3, 32'h1);
    idle(3, 2'd3);

    // Short and long pulses on bit1.
    cur_in = 8'hA7; idle(3, 2'd0);
    cur_in = 8'hA5; idle(12, 2'd3);
    cur_in = 8'hA7; idle(6, 2'd0);
    idle(12, 2'd3);

    // Continuous clears of bits 2/3 while they toggle: set must win.
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) cur_in = cur_in ^ 8'h0C;
      wr(2'd3, 32'h0000_000C);
    end
    idle(8, 2'd3);

    // Mask readback, reserved address, bit7 transitions with a clear between.
    wr(2'd1, 32'hFFFF_FFFF);
    idle(2, 2'd1);
    wr(2'd2, 32'hFFFF_FFFF);
    idle(2, 2'd2);
    wr(2'd3, 32'hFFFF_FFFF);
    cur_in = cur_in ^ 8'h80; idle(12, 2'd3);
    wr(2'd3, 32'h0000_0080);
    cur_in = cur_in ^ 8'h80; idle(12, 2'd3);

    // Build up captured edges with irq active, then reset.
    cur_in = cur_in ^ 8'h0F; idle(10, 2'd3);
    cur_in = cur_in ^ 8'h0F; idle(10, 2'd3);
    step(1'b1, cur_in, 1'b1, 1'b1, 2'd1, 32'h0);
    idle(3, 2'd1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic c, w, r;
      logic [1:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 5) == 0) cur_in = cur_in ^ 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 3) != 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      step(r, cur_in, c, w, a, d);
    end
    idle(4, 2'd0);

    @(negedge clk);
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (exp_q[d].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: got %0d pending expected 0", d, exp_q[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
